fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the RISC-V core. Owns the PC and issues word fetches to instruction memory over a req/gnt, rvalid handshake.
- Registers the returned instruction into IR for the decode stage: immediate generation, register file and control.
- Accepts PC redirects from execute (taken branch, JAL, JALR) and squashes wrong-path fetches.
- Detects misaligned redirect targets and memory response timeouts, and halts on either.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles in WAIT without imem_rvalid before timeout_err (range 2..255).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch byte address, word aligned
- imem_gnt  in  1  request accepted this cycle (only meaningful while imem_req=1)
- imem_rvalid  in  1  read data valid, exactly one per granted request, in order, at least 1 cycle after gnt
- imem_rdata  in  32  instruction word
- ir  out  32  registered instruction to decode
- ir_pc  out  32  PC of ir
- ir_valid  out  1  ir/ir_pc valid
- ir_ready  in  1  decode consumes ir this cycle when ir_valid=1
- redirect_valid  in  1  one-cycle redirect strobe from execute
- redirect_target  in  32  new PC
- halted  out  1  fetch stopped (error)
- misalign_err  out  1  sticky: redirect_target[1:0]!=0
- timeout_err  out  1  sticky: response timeout

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC; state=REQ; drop=0; tcnt=0. Outputs: ir=32'h0000_0013 (NOP), ir_pc=0, ir_valid=0, halted=0, both errors=0.
- imem_req=1 only in REQ. imem_addr=pc at all times. The first cycle after reset deassertion has imem_req=1 and imem_addr=RESET_PC.
- States:
  - REQ: hold imem_req and stable addr until imem_gnt. On gnt: go to WAIT, tcnt=0.
  - WAIT: tcnt increments each cycle. On imem_rvalid with drop=0: ir=imem_rdata, ir_pc=pc, ir_valid=1, pc=pc+4 (mod 2^32 wrap), go to HOLD. On imem_rvalid with drop=1: discard data, drop=0, go to REQ. If tcnt reaches TIMEOUT-1 without rvalid: timeout_err=1, go to HALT.
  - HOLD: ir_valid=1 with ir/ir_pc stable. On ir_ready: ir_valid=0, go to REQ. The next request is issued the following cycle.
  - HALT: imem_req=0, ir_valid=0, halted=1. Only rst exits.
- Best-case latency: req/gnt in cycle N, rvalid in N+1, ir_valid in N+2. Throughput is 1 instruction per 3 cycles minimum with ir_ready held high.
- Redirect has priority over every other event in the same cycle except rst:
  - Target misaligned (target[1:0]!=0): misalign_err=1, go to HALT in any state. pc is unchanged.
  - Otherwise pc=redirect_target, and:
    - REQ without gnt: stay in REQ. The new addr is presented next cycle; an ungranted request may change address.
    - REQ with simultaneous gnt: the old-address request is in flight, so go to WAIT with drop=1.
    - WAIT without rvalid: drop=1, stay in WAIT. tcnt continues counting.
    - WAIT with simultaneous rvalid: discard data, go to REQ.
    - HOLD: ir_valid=0 next cycle (instruction squashed even if ir_ready=1), go to REQ.
- imem_rvalid outside WAIT is ignored. imem_gnt while imem_req=0 is ignored.
- Error flags are sticky until rst. halted=1 iff state=HALT.
- rst mid-transaction abandons any outstanding response. The memory model must not return rvalid for a pre-reset request after reset.

Test Plan:
- Reset, RESET_PC=0x100, memory with gnt immediate and rvalid next cycle, words 0x00500093 and 0x00A00113, ir_ready=1 -> ir_valid pulses carrying (ir_pc=0x100, ir=0x00500093) then (0x104, 0x00A00113), one instruction every 3 cycles.
- ir_ready=0 for 5 cycles in HOLD -> ir and ir_pc stable, ir_valid=1, imem_req=0. Raising ir_ready -> imem_req=1 with addr=pc+4 the next cycle.
- Redirect to 0x200 while in WAIT (rvalid delayed 3 cycles, data 0xDEADBEEF) -> 0xDEADBEEF never appears on ir. Next request has addr=0x200, and the next ir_pc is 0x200.
- Redirect to 0x40 in the same cycle as gnt for 0x108 -> response for 0x108 discarded, next fetch at 0x40. Redirect to 0x80 in HOLD with ir_ready=1 -> no handshake for the held instruction; ir_valid=0 next cycle.
- Redirect to 0x202 -> misalign_err=1, halted=1, imem_req=0 thereafter. rst clears both flags and restarts at RESET_PC.
- Withhold rvalid with TIMEOUT=16 -> timeout_err=1 and halted=1 after 16 cycles in WAIT. pc=0xFFFFFFFC followed by a fetch -> pc wraps to 0x00000000.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus between the fetch stage and instruction memory.
//   imem_req    : fetch request (master -> slave)
//   imem_addr   : word-aligned fetch byte address (master -> slave)
//   imem_gnt    : request accepted this cycle (slave -> master)
//   imem_rvalid : read data valid, one per granted request, in order (slave -> master)
//   imem_rdata  : returned instruction word (slave -> master)
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues one word fetch at a time over
// the req/gnt + rvalid bus, and registers the returned word into IR for decode.
// Execute can redirect the PC at any time; fetches already in flight for the
// old path are squashed. Misaligned redirect targets and memory response
// timeouts halt the stage until reset.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   imem              : instruction-memory bus (master side)
//   ir, ir_pc         : registered instruction and its PC
//   ir_valid/ir_ready : handshake to decode
//   redirect_valid    : one-cycle redirect strobe, redirect_target is the new PC
//   halted            : stage stopped on an error
//   misalign_err      : sticky, redirect target not word aligned
//   timeout_err       : sticky, no response within TIMEOUT cycles
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master imem,
  output logic [31:0]  ir,
  output logic [31:0]  ir_pc,
  output logic         ir_valid,
  input  logic         ir_ready,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_target,
  output logic         halted,
  output logic         misalign_err,
  output logic         timeout_err
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [7:0]  TCNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        drop_q, drop_d;
  logic [7:0]  tcnt_q, tcnt_d, tcnt_inc;
  logic        mis_q, mis_d;
  logic        to_q, to_d;
  logic        redir_ok, redir_bad;

  assign redir_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
  assign redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);
  // Saturate so repeated redirects in WAIT cannot wrap the counter past the limit.
  assign tcnt_inc  = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    drop_d  = drop_q;
    tcnt_d  = tcnt_q;
    mis_d   = mis_q;
    to_d    = to_q;
    case (state_q)
      S_REQ: begin
        if (redir_bad) begin
          mis_d   = 1'b1;
          state_d = S_HALT;
        end else if (redir_ok) begin
          pc_d = redirect_target;
          // A granted old-address request is already in flight: drop its response.
          if (imem.imem_gnt) begin
            state_d = S_WAIT;
            drop_d  = 1'b1;
            tcnt_d  = 8'd0;
          end
        end else if (imem.imem_gnt) begin
          state_d = S_WAIT;
          drop_d  = 1'b0;
          tcnt_d  = 8'd0;
        end
      end
      S_WAIT: begin
        if (redir_bad) begin
          mis_d   = 1'b1;
          state_d = S_HALT;
        end else if (redir_ok) begin
          pc_d = redirect_target;
          if (imem.imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d = 1'b1;
            tcnt_d = tcnt_inc;
          end
        end else if (imem.imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            ir_d    = imem.imem_rdata;
            ir_pc_d = pc_q;
            pc_d    = pc_q + 32'd4;
            state_d = S_HOLD;
          end
        end else if (tcnt_q >= TCNT_LAST) begin
          to_d    = 1'b1;
          state_d = S_HALT;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end
      S_HOLD: begin
        if (redir_bad) begin
          mis_d   = 1'b1;
          state_d = S_HALT;
        end else if (redir_ok) begin
          pc_d    = redirect_target;
          state_d = S_REQ;
        end else if (ir_ready) begin
          state_d = S_REQ;
        end
      end
      S_HALT: begin
        if (redir_bad) begin
          mis_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      ir_q    <= NOP;
      ir_pc_q <= 32'd0;
      drop_q  <= 1'b0;
      tcnt_q  <= 8'd0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      drop_q  <= drop_d;
      tcnt_q  <= tcnt_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
    end
  end

  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = pc_q;
  assign ir             = ir_q;
  assign ir_pc          = ir_pc_q;
  assign ir_valid       = (state_q == S_HOLD);
  assign halted         = (state_q == S_HALT);
  assign misalign_err   = mis_q;
  assign timeout_err    = to_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table-driven fetch latency/throughput vectors, directed
// redirect/error sequences, and a randomized run against a transaction-level
// model of the expected instruction stream.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          TMO    = 16;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir, ir_pc;
  logic        ir_valid, ir_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halted, misalign_err, timeout_err;

  fetch_unit_if mif ();

  fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem            (mif),
    .ir              (ir),
    .ir_pc           (ir_pc),
    .ir_valid        (ir_valid),
    .ir_ready        (ir_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halted          (halted),
    .misalign_err    (misalign_err),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Memory model state
  int gnt_lat = 0;
  int rv_lat  = 1;
  int req_cnt = 0;
  bit withhold = 1'b0;
  typedef struct { logic [31:0] data; int ready; } rsp_t;
  rsp_t pend[$];
  logic [31:0] ovr [logic [31:0]];

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic regnt();
    mif.imem_gnt = mif.imem_req && !rst && (req_cnt >= gnt_lat);
  endtask

  // One clock: commit the grant seen before the edge, then drive the memory
  // outputs for the new cycle 1 time unit after the edge.
  task automatic tick();
    if (!rst && mif.imem_req && mif.imem_gnt)
      pend.push_back('{memw(mif.imem_addr), cyc + rv_lat});
    if (mif.imem_req && !mif.imem_gnt) req_cnt++;
    else req_cnt = 0;
    @(posedge clk);
    #1;
    cyc++;
    mif.imem_rvalid = 1'b0;
    mif.imem_rdata  = $urandom;
    if (!rst && !withhold && pend.size() > 0 && pend[0].ready <= cyc) begin
      mif.imem_rvalid = 1'b1;
      mif.imem_rdata  = pend[0].data;
      pend.delete(0);
    end
    regnt();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 32'd0;
    ir_ready = 1'b1;
    pend.delete();
    withhold = 1'b0;
    gnt_lat = 0;
    rv_lat = 1;
    req_cnt = 0;
    mif.imem_gnt = 1'b0;
    mif.imem_rvalid = 1'b0;
    mif.imem_rdata = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    regnt();
  endtask

  task automatic wait_valid(input string nm, output int n);
    n = 0;
    while (!ir_valid && n < 60) begin tick(); n++; end
    if (!ir_valid) chk({nm, " bound"}, 32'd0, 32'd1);
  endtask

  task automatic wait_req(input string nm, output int n);
    n = 0;
    while (!mif.imem_req && n < 60) begin tick(); n++; end
    if (!mif.imem_req) chk({nm, " bound"}, 32'd0, 32'd1);
  endtask

  typedef struct { int gl; int rl; int hold; int exp_lat; int exp_gap; } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vt[6];
    logic [31:0] exp_pc, ir_hold;
    int          n, ok, seen, w, deliv;

    // gl: cycles of req before gnt, rl: gnt->rvalid cycles, hold: cycles ir_ready low
    // exp_lat: first req cycle -> ir_valid, exp_gap: ir_valid -> next req
    vt[0] = '{0, 1, 0, 2, 1};
    vt[1] = '{0, 1, 0, 2, 1};
    vt[2] = '{1, 2, 0, 4, 1};
    vt[3] = '{0, 1, 5, 2, 6};
    vt[4] = '{2, 3, 2, 6, 3};
    vt[5] = '{0, 4, 1, 5, 2};

    ovr[32'h100] = 32'h0050_0093;
    ovr[32'h104] = 32'h00A0_0113;

    // Reset values
    do_reset();
    chk("rst ir", ir, NOP);
    chk("rst ir_pc", ir_pc, 32'd0);
    chk("rst flags", 32'({ir_valid, halted, misalign_err, timeout_err}), 32'd0);
    chk("rst req", 32'(mif.imem_req), 32'd1);
    chk("rst addr", mif.imem_addr, RST_PC);

    // Table-driven fetch vectors
    exp_pc = RST_PC;
    foreach (vt[i]) begin
      gnt_lat = vt[i].gl;
      rv_lat  = vt[i].rl;
      regnt();
      chk("vec addr", mif.imem_addr, exp_pc);
      wait_valid("vec valid", n);
      chk("vec latency", n, vt[i].exp_lat);
      chk("vec ir_pc", ir_pc, exp_pc);
      chk("vec ir", ir, memw(exp_pc));
      ir_hold = ir;
      ok = 1;
      n = 0;
      while (!mif.imem_req && n < 60) begin
        ir_ready = (n >= vt[i].hold);
        tick();
        n++;
        if (ir_valid && (ir !== ir_hold || ir_pc !== exp_pc || mif.imem_req)) ok = 0;
      end
      chk("vec hold stable", ok, 1);
      chk("vec gap", n, vt[i].exp_gap);
      exp_pc += 32'd4;
    end
    ir_ready = 1'b1;

    // Redirect while waiting for a slow response
    chk("pre-wait addr", mif.imem_addr, 32'h118);
    ovr[32'h118] = 32'hDEAD_BEEF;
    gnt_lat = 0;
    rv_lat  = 4;
    regnt();
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    tick();
    redirect_valid = 1'b0;
    seen = 0;
    n = 0;
    while (!mif.imem_req && n < 60) begin
      if (ir === 32'hDEAD_BEEF || ir_valid) seen = 1;
      tick();
      n++;
    end
    chk("wait squash", seen, 0);
    chk("wait redir addr", mif.imem_addr, 32'h200);
    rv_lat = 1;
    wait_valid("wait redir valid", n);
    chk("wait redir ir_pc", ir_pc, 32'h200);
    chk("wait redir ir", ir, memw(32'h200));
    tick();

    // Redirect in REQ without gnt, then redirect together with gnt
    chk("req seq addr", mif.imem_addr, 32'h204);
    gnt_lat = 3;
    regnt();
    redirect_valid  = 1'b1;
    redirect_target = 32'h108;
    tick();
    redirect_valid = 1'b0;
    chk("req nogn req", 32'(mif.imem_req), 32'd1);
    chk("req nogn addr", mif.imem_addr, 32'h108);
    ovr[32'h108] = 32'hBAD0_0108;
    gnt_lat = 0;
    rv_lat  = 1;
    regnt();
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    tick();
    redirect_valid = 1'b0;
    wait_req("gnt redir req", n);
    chk("gnt redir addr", mif.imem_addr, 32'h40);
    wait_valid("gnt redir valid", n);
    chk("gnt redir ir_pc", ir_pc, 32'h40);
    chk("gnt redir ir", ir, memw(32'h40));

    // Redirect in HOLD with ir_ready=1 squashes the held instruction
    ir_ready        = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h80;
    tick();
    redirect_valid = 1'b0;
    chk("hold redir valid", 32'(ir_valid), 32'd0);
    chk("hold redir req", 32'(mif.imem_req), 32'd1);
    chk("hold redir addr", mif.imem_addr, 32'h80);
    wait_valid("hold redir fetch", n);
    chk("hold redir ir_pc", ir_pc, 32'h80);

    // Misaligned redirect halts until reset
    redirect_valid  = 1'b1;
    redirect_target = 32'h202;
    tick();
    redirect_valid = 1'b0;
    chk("mis flags", 32'({misalign_err, halted, timeout_err, ir_valid}), 32'b1100);
    ok = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (mif.imem_req || !halted || !misalign_err) ok = 0;
    end
    chk("mis stays halted", ok, 1);
    do_reset();
    chk("mis rst flags", 32'({misalign_err, halted}), 32'd0);
    chk("mis rst addr", mif.imem_addr, RST_PC);

    // Response timeout
    withhold = 1'b1;
    tick();
    w = 0;
    n = 0;
    while (!halted && n < 60) begin
      if (!mif.imem_req && !ir_valid) w++;
      tick();
      n++;
    end
    chk("tmo wait cycles", w, TMO);
    chk("tmo flags", 32'({timeout_err, halted, misalign_err, mif.imem_req}), 32'b1100);
    do_reset();
    chk("tmo rst flag", 32'(timeout_err), 32'd0);

    // PC wrap
    gnt_lat = 5;
    regnt();
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap addr", mif.imem_addr, 32'hFFFF_FFFC);
    gnt_lat = 0;
    regnt();
    wait_valid("wrap valid", n);
    chk("wrap ir_pc", ir_pc, 32'hFFFF_FFFC);
    chk("wrap ir", ir, memw(32'hFFFF_FFFC));
    tick();
    chk("wrap next addr", mif.imem_addr, 32'h0);

    // Randomized run against the expected instruction stream
    do_reset();
    exp_pc = RST_PC;
    deliv = 0;
    for (int k = 0; k < 3000; k++) begin
      if (ir_valid) begin
        chk("rnd ir_pc", ir_pc, exp_pc);
        chk("rnd ir", ir, memw(ir_pc));
      end
      chk("rnd status", 32'({halted, misalign_err, timeout_err, mif.imem_addr[1:0]}), 32'd0);
      gnt_lat = $urandom_range(0, 2);
      rv_lat  = $urandom_range(1, 4);
      regnt();
      ir_ready        = ($urandom_range(0, 9) < 7);
      redirect_valid  = ($urandom_range(0, 19) == 0);
      redirect_target = 32'($urandom_range(0, 255)) << 2;
      if (redirect_valid) begin
        exp_pc = redirect_target;
      end else if (ir_valid && ir_ready) begin
        exp_pc += 32'd4;
        deliv++;
      end
      tick();
    end
    redirect_valid = 1'b0;
    chk("rnd progress", 32'(deliv > 50), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
